// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_PC_MAX   = 32'h0000_6FFC;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_NEXT  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_RANGE    = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    // Instruction word plus the PC it was fetched from, as offered to decode.
    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } fetch_pkt_t;

endpackage

// File: rtl/pc_check.sv
// Combinational legality check for a candidate next PC.
module pc_check
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_MIN = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_MAX = DEFAULT_PC_MAX
) (
    input  logic [31:0] npc,
    output logic        ok,
    output logic [1:0]  cause
);

    // Misalignment is reported ahead of a range violation.
    always_comb begin
        ok    = 1'b1;
        cause = CAUSE_NONE;
        if (npc[1:0] != 2'b00) begin
            ok    = 1'b0;
            cause = CAUSE_MISALIGN;
        end else if ((npc < PC_MIN) || (npc > PC_MAX)) begin
            ok    = 1'b0;
            cause = CAUSE_RANGE;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch with decode hand-off and sticky faults.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_MAX      = DEFAULT_PC_MAX,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic [31:0] npc,
    input  logic        npc_valid,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fetch_count
);

    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n;
    fetch_pkt_t   held, held_n;
    logic [31:0]  count_n;
    logic [1:0]   cause_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic         npc_take;
    logic         npc_ok;
    logic [1:0]   npc_cause;

    // One checker serves both the zero-bubble HOLD path and the NEXT path.
    pc_check #(
        .PC_MIN(RESET_PC),
        .PC_MAX(PC_MAX)
    ) u_pc_check (
        .npc  (npc),
        .ok   (npc_ok),
        .cause(npc_cause)
    );

    assign imem_addr = pc;
    assign inst      = held.word;
    assign inst_pc   = held.pc;

    // Next-state and next-datapath values; timeout counter is zero outside FETCH.
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        held_n   = held;
        count_n  = fetch_count;
        cause_n  = fault_cause;
        tcnt_n   = '0;
        npc_take = 1'b0;

        case (state)
            ST_FETCH: begin
                if (imem_ack) begin
                    held_n.word = imem_rdata;
                    held_n.pc   = pc;
                    state_n     = ST_HOLD;
                end else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
                    state_n = ST_FAULT;
                    cause_n = CAUSE_TIMEOUT;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            ST_HOLD: begin
                if (inst_ready) begin
                    count_n = fetch_count + 32'd1;
                    if (npc_valid) begin
                        npc_take = 1'b1;
                    end else begin
                        state_n = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                if (npc_valid) begin
                    npc_take = 1'b1;
                end
            end
            ST_FAULT: begin
                state_n = ST_FAULT;
            end
            default: begin
                state_n = ST_FETCH;
            end
        endcase

        if (npc_take) begin
            if (npc_ok) begin
                pc_n    = npc;
                state_n = ST_FETCH;
            end else begin
                state_n = ST_FAULT;
                cause_n = npc_cause;
            end
        end
    end

    // State and datapath registers; control outputs are decoded from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            held        <= '0;
            fetch_count <= 32'd0;
            fault_cause <= CAUSE_NONE;
            tcnt        <= '0;
            imem_req    <= 1'b1;
            inst_valid  <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            held        <= held_n;
            fetch_count <= count_n;
            fault_cause <= cause_n;
            tcnt        <= tcnt_n;
            imem_req    <= (state_n == ST_FETCH);
            inst_valid  <= (state_n == ST_HOLD);
            fault       <= (state_n == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver pushes expectations, monitor checks.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] PCMAX  = 32'h0000_6FFC;
    localparam int          TMO    = 16;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] npc;
    logic        npc_valid;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fetch_count;

    fetch_unit #(
        .RESET_PC   (RST_PC),
        .PC_MAX     (PCMAX),
        .ACK_TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .npc        (npc),
        .npc_valid  (npc_valid),
        .fault      (fault),
        .fault_cause(fault_cause),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int cyc; } fetch_exp_t;
    typedef struct { logic [31:0] word; logic [31:0] pc; logic [31:0] cnt; } inst_exp_t;
    typedef struct { logic [1:0] cause; int cyc; } fault_exp_t;

    fetch_exp_t fq[$];
    inst_exp_t  iq[$];
    fault_exp_t flq[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: architectural PC and accepted-instruction count.
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic missing(input string name);
        checks++;
        errors++;
        $display("FAIL %s: DUT event with no expected entry (cycle %0d)", name, cyc);
    endtask

    // Legality of a next PC from first principles: word aligned, inside the window.
    function automatic logic [1:0] exp_cause(input logic [31:0] a);
        if ((a % 4) != 0) return 2'b01;
        if (a < RST_PC || a > PCMAX) return 2'b10;
        return 2'b00;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: samples on the falling edge and checks against the queues.
    initial begin
        bit          prev_req;
        bit          prev_fault;
        logic [31:0] cur_addr;
        logic [1:0]  cur_cause;
        fetch_exp_t  fe;
        inst_exp_t   ie;
        fault_exp_t  xe;
        prev_req   = 1'b0;
        prev_fault = 1'b0;
        cur_addr   = '0;
        cur_cause  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_req   = 1'b0;
                prev_fault = 1'b0;
            end else begin
                if (imem_req) begin
                    if (!prev_req) begin
                        if (fq.size() == 0) missing("fetch_start");
                        else begin
                            fe = fq.pop_front();
                            cur_addr = fe.addr;
                            chk("fetch_addr", imem_addr, fe.addr);
                            chk("fetch_cycle", cyc, fe.cyc);
                        end
                    end else begin
                        chk("fetch_addr_stable", imem_addr, cur_addr);
                    end
                end
                if (inst_valid) begin
                    if (iq.size() == 0) missing("inst_offer");
                    else begin
                        ie = iq[0];
                        chk("inst", inst, ie.word);
                        chk("inst_pc", inst_pc, ie.pc);
                        if (inst_ready) begin
                            chk("fetch_count", fetch_count, ie.cnt);
                            void'(iq.pop_front());
                        end
                    end
                end
                if (fault) begin
                    if (!prev_fault) begin
                        if (flq.size() == 0) missing("fault_entry");
                        else begin
                            xe = flq.pop_front();
                            cur_cause = xe.cause;
                            chk("fault_cause", 32'(fault_cause), 32'(xe.cause));
                            chk("fault_cycle", cyc, xe.cyc);
                        end
                    end else begin
                        chk("fault_cause_held", 32'(fault_cause), 32'(cur_cause));
                    end
                    chk("fault_req_low", 32'(imem_req), 32'd0);
                    chk("fault_valid_low", 32'(inst_valid), 32'd0);
                end
                prev_req   = imem_req;
                prev_fault = fault;
            end
        end
    end

    // Advance to one time unit after the next rising edge and idle the inputs.
    task automatic next_slot();
        @(posedge clk);
        #1;
        imem_ack   = 1'b0;
        npc_valid  = 1'b0;
        inst_ready = 1'b0;
        imem_rdata = $urandom;
        npc        = $urandom;
    endtask

    task automatic push_fetch(input logic [31:0] a);
        fetch_exp_t e;
        e.addr = a;
        e.cyc  = cyc;
        fq.push_back(e);
    endtask

    task automatic push_fault(input logic [1:0] c);
        fault_exp_t e;
        e.cause = c;
        e.cyc   = cyc;
        flq.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next_slot();
        #3;
        chk("rst_imem_req", 32'(imem_req), 32'd1);
        chk("rst_imem_addr", imem_addr, RST_PC);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fault_cause", 32'(fault_cause), 32'd0);
        chk("rst_fetch_count", fetch_count, 32'd0);
        next_slot();
        reset = 1'b0;
        m_pc  = RST_PC;
        m_cnt = 32'd0;
        iq.delete();
        push_fetch(RST_PC);
    endtask

    // Respond to the current fetch after lat idle cycles; lat >= TMO never acks.
    task automatic do_fetch(input int lat, input logic [31:0] word, output bit timed_out);
        inst_exp_t e;
        for (int i = 0; i < lat && i < TMO; i++) begin
            npc_valid = 1'($urandom);
            next_slot();
        end
        if (lat >= TMO) begin
            push_fault(2'b11);
            timed_out = 1'b1;
            return;
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        npc_valid  = 1'($urandom);
        e.word = word;
        e.pc   = m_pc;
        e.cnt  = m_cnt;
        iq.push_back(e);
        next_slot();
        timed_out = 1'b0;
    endtask

    // Stall decode, accept, then supply target either with the handshake or later.
    task automatic do_hold(input int stall, input bit same, input int dly,
                           input logic [31:0] target, output bit faulted);
        logic [1:0] c;
        for (int i = 0; i < stall; i++) begin
            imem_ack   = 1'($urandom);
            npc_valid  = 1'($urandom);
            next_slot();
        end
        inst_ready = 1'b1;
        imem_ack   = 1'($urandom);
        if (same) begin
            npc_valid = 1'b1;
            npc       = target;
        end
        next_slot();
        m_cnt = m_cnt + 32'd1;
        if (!same) begin
            for (int i = 0; i < dly; i++) begin
                imem_ack = 1'($urandom);
                next_slot();
            end
            npc_valid = 1'b1;
            npc       = target;
            next_slot();
        end
        c = exp_cause(target);
        if (c != 2'b00) begin
            push_fault(c);
            faulted = 1'b1;
        end else begin
            m_pc = target;
            push_fetch(target);
            faulted = 1'b0;
        end
    endtask

    task automatic linger_and_reset();
        for (int i = 0; i < 4; i++) begin
            imem_ack   = 1'($urandom);
            npc_valid  = 1'($urandom);
            inst_ready = 1'($urandom);
            next_slot();
        end
        do_reset();
    endtask

    function automatic logic [31:0] rand_npc(input logic [31:0] cur);
        int unsigned r;
        logic [31:0] legal;
        r = $urandom_range(0, 19);
        legal = RST_PC + 32'(4 * $urandom_range(0, (PCMAX - RST_PC) / 4));
        case (r)
            0:       return legal + 32'($urandom_range(1, 3));
            1:       return RST_PC - 32'(4 * $urandom_range(1, 8));
            2:       return PCMAX + 32'(4 * $urandom_range(1, 8));
            3:       return PCMAX + 32'd1;
            4:       return RST_PC;
            5:       return PCMAX;
            6, 7:    return legal;
            default: return (cur + 32'd4 <= PCMAX) ? cur + 32'd4 : RST_PC;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        bit to;
        bit f;
        reset      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        inst_ready = 1'b0;
        npc        = '0;
        npc_valid  = 1'b0;
        do_reset();

        do_fetch(1, 32'h2408_0001, to);
        do_hold(0, 1'b0, 1, 32'h0000_3004, f);
        do_fetch(0, $urandom, to);
        do_hold(0, 1'b1, 0, 32'h0000_3010, f);
        do_fetch(2, $urandom, to);
        do_hold(5, 1'b0, 0, 32'h0000_3014, f);
        do_fetch(TMO - 1, $urandom, to);
        do_hold(0, 1'b1, 0, 32'h0000_3002, f);
        linger_and_reset();

        do_fetch(0, $urandom, to);
        do_hold(1, 1'b0, 2, 32'h0000_2FFC, f);
        linger_and_reset();
        do_fetch(3, $urandom, to);
        do_hold(0, 1'b1, 0, 32'h0000_7000, f);
        linger_and_reset();
        do_fetch(TMO, $urandom, to);
        linger_and_reset();

        for (int n = 0; n < 200; n++) begin
            int lat;
            lat = ($urandom_range(0, 24) == 0) ? TMO : int'($urandom_range(0, TMO - 1));
            do_fetch(lat, $urandom, to);
            if (to) begin
                linger_and_reset();
                continue;
            end
            do_hold(int'($urandom_range(0, 4)), 1'($urandom), int'($urandom_range(0, 3)),
                    rand_npc(m_pc), f);
            if (f) linger_and_reset();
        end

        next_slot();
        next_slot();
        chk("sb_fetch_left", fq.size(), 32'd0);
        chk("sb_inst_left", iq.size(), 32'd0);
        chk("sb_fault_left", flq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_3000, giving the PC loaded at reset.
REQ-002 The block SHALL have parameter PC_MAX, default 32'h0000_6FFC, giving the highest legal fetch address.
REQ-003 The block SHALL have parameter ACK_TIMEOUT, default 16, giving the maximum number of cycles to wait for imem_ack.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port imem_req, output, 1 bit: instruction memory request.
REQ-007 The block SHALL have port imem_addr, output, 32 bits: fetch address, equal to the current PC.
REQ-008 The block SHALL have port imem_ack, input, 1 bit: read data valid this cycle.
REQ-009 The block SHALL have port imem_rdata, input, 32 bits: instruction word.
REQ-010 The block SHALL have port inst_valid, output, 1 bit: an instruction is offered to decode.
REQ-011 The block SHALL have port inst_ready, input, 1 bit: decode accepts the offered instruction.
REQ-012 The block SHALL have port inst, output, 32 bits: held instruction word.
REQ-013 The block SHALL have port inst_pc, output, 32 bits: PC of the held instruction.
REQ-014 The block SHALL have port npc, input, 32 bits: next PC from the next-PC logic.
REQ-015 The block SHALL have port npc_valid, input, 1 bit: npc is valid this cycle.
REQ-016 The block SHALL have port fault, output, 1 bit: sticky fault flag.
REQ-017 The block SHALL have port fault_cause, output, 2 bits: 00 none, 01 misaligned, 10 out of range, 11 timeout.
REQ-018 The block SHALL have port fetch_count, output, 32 bits: number of accepted instructions.

Function
REQ-019 The FSM SHALL have states FETCH, HOLD, NEXT and FAULT.
REQ-020 In FETCH: imem_req=1; imem_addr=pc; on imem_ack, latch imem_rdata into inst, pc into inst_pc, and go to HOLD.
REQ-021 In HOLD: inst_valid=1; inst and inst_pc are stable until the handshake (inst_valid&inst_ready).
REQ-022 On the HOLD handshake with npc_valid=0: go to NEXT and increment fetch_count by 1 (modulo 2^32).
REQ-023 On the HOLD handshake with npc_valid=1 in the same cycle: check npc, then load pc and go directly to FETCH (zero bubble); increment fetch_count.
REQ-024 In NEXT: wait for npc_valid; on npc_valid, check npc, then load pc=npc and go to FETCH.
REQ-025 npc_valid asserted in FETCH, or in HOLD without the handshake, SHALL be ignored.
REQ-026 npc check: npc[1:0]!=0 -> FAULT with cause 01; else npc<RESET_PC or npc>PC_MAX -> FAULT with cause 10; misaligned takes priority.
REQ-027 A timeout counter SHALL clear on entry to FETCH and count each FETCH cycle without imem_ack; when it reaches ACK_TIMEOUT -> FAULT with cause 11.
REQ-028 An imem_ack in the same cycle that the timeout is reached SHALL win: data is latched and there is no fault.
REQ-029 FAULT SHALL be absorbing until reset: fault=1, imem_req=0, inst_valid=0, fault_cause held, pc not updated.
REQ-030 imem_ack outside FETCH SHALL be ignored.
REQ-031 imem_req and inst_valid SHALL be driven from registered state only, with no combinational path from an input.

Reset
REQ-032 On reset: state=FETCH, pc=RESET_PC, inst=0, inst_pc=0, fetch_count=0, fault=0, fault_cause=00, timeout counter=0.
REQ-033 Reset asserted mid-operation, including in FAULT, SHALL override everything in that cycle; the next cycle presents imem_req=1 with imem_addr=RESET_PC.

Structure
REQ-034 A shared package SHALL hold the state encoding, the fault_cause encodings, and the RESET_PC and PC_MAX defaults.
REQ-035 The npc legality check SHALL be one combinational sub-module, pc_check (inputs npc; outputs ok and cause), reused by the next-PC path.

Verification
REQ-036 Reset, then ack after 1 cycle with rdata=32'h2408_0001 -> imem_addr=3000; inst=24080001, inst_pc=3000; inst_valid=1.
REQ-037 Handshake, then npc=3004 two cycles later -> next imem_addr=3004; fetch_count=1.
REQ-038 Handshake with npc_valid=1 and npc=3010 in the same cycle -> FETCH at 3010 on the following cycle, with no NEXT cycle.
REQ-039 npc=3002 -> fault=1, cause=01; npc=2FFC -> cause=10; npc=7000 -> cause=10; imem_req stays 0 until reset.
REQ-040 imem_ack withheld for 16 FETCH cycles -> fault with cause=11; ack on the 16th cycle -> no fault.
REQ-041 inst_ready low for 5 cycles in HOLD -> inst and inst_pc unchanged; spurious imem_ack and npc_valid during that time ignored.
